// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants (640x480 @ 60 Hz defaults), the counter width,
//   and the per-axis phase enumeration used by vga_axis_counter and
//   vga_sync_gen.
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1024;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  // Phase that follows ph once ph's length is exhausted.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      ACTIVE:  next_phase = FRONT;
      FRONT:   next_phase = SYNC;
      SYNC:    next_phase = BACK;
      BACK:    next_phase = ACTIVE;
      default: next_phase = ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One timing axis: a position counter plus a phase FSM
//   ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Both step only when
//   advance_i is high. count_o/phase_o describe the current position;
//   wrap_o is high in the advance cycle that moves the last position back
//   to 0.
// Ports
//   clk_i        : clock, rising edge
//   reset_i      : synchronous active-high reset (count 0, phase ACTIVE)
//   advance_i    : step to the next position this cycle
//   len_*_i      : phase lengths, each at least 1
//   count_o      : current position
//   phase_o      : phase of current position
//   wrap_o       : advancing out of the last position this cycle
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             advance_i,
  input  logic [CNT_W-1:0] len_visible_i,
  input  logic [CNT_W-1:0] len_front_i,
  input  logic [CNT_W-1:0] len_sync_i,
  input  logic [CNT_W-1:0] len_back_i,
  output logic [CNT_W-1:0] count_o,
  output phase_e           phase_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] phase_last_s;
  logic             phase_end_s;
  logic             axis_last_s;

  // Last position belonging to the current phase (cumulative boundary).
  // A total of exactly 1024 wraps to 0 and the -1 yields 1023 as required.
  always_comb begin
    phase_last_s = len_visible_i - 10'd1;
    case (phase_q)
      ACTIVE:  phase_last_s = len_visible_i - 10'd1;
      FRONT:   phase_last_s = len_visible_i + len_front_i - 10'd1;
      SYNC:    phase_last_s = len_visible_i + len_front_i + len_sync_i - 10'd1;
      BACK:    phase_last_s = len_visible_i + len_front_i + len_sync_i + len_back_i - 10'd1;
      default: phase_last_s = len_visible_i - 10'd1;
    endcase
  end

  assign phase_end_s = (count_q == phase_last_s);
  assign axis_last_s = phase_end_s && (phase_q == BACK);

  // Next position and phase; nothing moves without advance.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance_i) begin
      if (phase_end_s) begin
        phase_d = next_phase(phase_q);
      end else begin
        phase_d = phase_q;
      end
      if (axis_last_s) begin
        count_d = 10'd0;
      end else begin
        count_d = count_q + 10'd1;
      end
    end else begin
      count_d = count_q;
      phase_d = phase_q;
    end
  end

  // Position and phase state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 10'd0;
      phase_q <= ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count_o = count_q;
  assign phase_o = phase_q;
  assign wrap_o  = advance_i && axis_last_s;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA timing generator. In every pix_en cycle it registers the outputs for
//   the current (hcount, vcount) and advances the counters on the same edge,
//   so outputs are valid from the cycle after pix_en and held until the
//   next pix_en. Pulses last one main_clock cycle.
// Ports
//   main_clock  : 50 MHz clock, rising edge
//   reset       : synchronous active-high reset
//   pix_en      : single-cycle pixel enable
//   hsync/vsync : sync outputs, active low
//   video_on    : current pixel is visible
//   pixel_x/y   : visible pixel coordinates, 0 outside the visible area
//   line_start  : pulse when emitting hcount 0
//   frame_start : pulse when emitting (0,0)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
)(
  input  logic             main_clock,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Totals must fit the 10-bit counters; every phase needs at least one step.
  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("vga_sync_gen: timing totals exceed the 10-bit counter range");
  end
  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_phase
    $error("vga_sync_gen: every timing phase must be at least 1 long");
  end

  logic [CNT_W-1:0] h_count_s, v_count_s;
  phase_e           h_phase_s, v_phase_s;
  logic             h_wrap_s, v_wrap_s, v_adv_s, visible_s;

  assign v_adv_s = pix_en && h_wrap_s;

  vga_axis_counter u_h_axis (
    .clk_i         (main_clock),
    .reset_i       (reset),
    .advance_i     (pix_en),
    .len_visible_i (CNT_W'(H_VISIBLE)),
    .len_front_i   (CNT_W'(H_FRONT)),
    .len_sync_i    (CNT_W'(H_SYNC)),
    .len_back_i    (CNT_W'(H_BACK)),
    .count_o       (h_count_s),
    .phase_o       (h_phase_s),
    .wrap_o        (h_wrap_s)
  );

  vga_axis_counter u_v_axis (
    .clk_i         (main_clock),
    .reset_i       (reset),
    .advance_i     (v_adv_s),
    .len_visible_i (CNT_W'(V_VISIBLE)),
    .len_front_i   (CNT_W'(V_FRONT)),
    .len_sync_i    (CNT_W'(V_SYNC)),
    .len_back_i    (CNT_W'(V_BACK)),
    .count_o       (v_count_s),
    .phase_o       (v_phase_s),
    .wrap_o        (v_wrap_s)
  );

  assign visible_s = (h_phase_s == ACTIVE) && (v_phase_s == ACTIVE);

  logic             hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  // Origin flags: the next emitted position starts a line / a frame. They are
  // set by reset and by the axis wraps, so pulses follow the counters exactly.
  logic             line_origin_q, line_origin_d, frame_origin_q, frame_origin_d;

  // Emit outputs for the current position on pix_en; otherwise hold levels
  // and drop the pulses.
  always_comb begin
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    video_on_d     = video_on_q;
    pixel_x_d      = pixel_x_q;
    pixel_y_d      = pixel_y_q;
    line_origin_d  = line_origin_q;
    frame_origin_d = frame_origin_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    if (pix_en) begin
      hsync_d    = (h_phase_s != SYNC);
      vsync_d    = (v_phase_s != SYNC);
      video_on_d = visible_s;
      if (visible_s) begin
        pixel_x_d = h_count_s;
        pixel_y_d = v_count_s;
      end else begin
        pixel_x_d = 10'd0;
        pixel_y_d = 10'd0;
      end
      line_start_d   = line_origin_q;
      frame_start_d  = frame_origin_q;
      line_origin_d  = h_wrap_s;
      frame_origin_d = v_wrap_s;
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Output and origin-flag registers; reset beats a simultaneous pix_en.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      video_on_q     <= 1'b0;
      pixel_x_q      <= 10'd0;
      pixel_y_q      <= 10'd0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      line_origin_q  <= 1'b1;
      frame_origin_q <= 1'b1;
    end else begin
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_on_q     <= video_on_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      line_origin_q  <= line_origin_d;
      frame_origin_q <= frame_origin_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   dut_a runs default 640x480 timing for line-level behaviour, hold, and
//   mid-line reset. dut_b runs a 16x12 total timing (visible 8x6, hsync at
//   h 10..12, vsync at v 8..9) so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a, pe_a, hs_a, vs_a, von_a, ls_a, fs_a;
  logic [9:0] px_a, py_a;
  logic       rst_b, pe_b, hs_b, vs_b, von_b, ls_b, fs_b;
  logic [9:0] px_b, py_b;

  vga_sync_gen dut_a (
    .main_clock (clk),  .reset (rst_a), .pix_en (pe_a),
    .hsync (hs_a), .vsync (vs_a), .video_on (von_a),
    .pixel_x (px_a), .pixel_y (py_a),
    .line_start (ls_a), .frame_start (fs_a)
  );

  vga_sync_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
  ) dut_b (
    .main_clock (clk),  .reset (rst_b), .pix_en (pe_b),
    .hsync (hs_b), .vsync (vs_b), .video_on (von_b),
    .pixel_x (px_b), .pixel_y (py_b),
    .line_start (ls_b), .frame_start (fs_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive pix_en after a falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic tick_a(input logic en);
    pe_a = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_b(input logic en);
    pe_b = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full small frame starting at an emit of (0,0), gap idle cycles between
  // pixel enables, then the first emit of the following frame.
  task automatic run_frame_b(input int gap, input string tag);
    int ls_n, fs_n, vs_low, vs_first, hs_low, von_n, err, idle_pulse, h, v, c0;
    logic exp_vid;
    ls_n = 0; fs_n = 0; vs_low = 0; vs_first = -1; hs_low = 0;
    von_n = 0; err = 0; idle_pulse = 0; c0 = 0;
    for (int e = 0; e < 192; e++) begin
      h = e % 16;
      v = e / 16;
      tick_b(1'b1);
      if (e == 0) c0 = cyc;
      if (ls_b) ls_n++;
      if (fs_b) fs_n++;
      if (!hs_b) hs_low++;
      if (von_b) von_n++;
      if (!vs_b) begin
        vs_low++;
        if (vs_first < 0) vs_first = e;
      end
      exp_vid = (h < 8) && (v < 6);
      if (hs_b !== !(h >= 10 && h < 13) || vs_b !== !(v >= 8 && v < 10) ||
          von_b !== exp_vid || px_b !== (exp_vid ? 10'(h) : 10'd0) ||
          py_b !== (exp_vid ? 10'(v) : 10'd0) || ls_b !== (h == 0) || fs_b !== (e == 0))
        err++;
      for (int g = 0; g < gap; g++) begin
        tick_b(1'b0);
        if (ls_b || fs_b) idle_pulse++;
      end
    end
    tick_b(1'b1);
    check({tag, "_next_fs"}, fs_b, 32'd1);
    check({tag, "_next_px"}, px_b, 32'd0);
    check({tag, "_cycles"}, cyc - c0, 32'(192 * (gap + 1)));
    check({tag, "_line_starts"}, ls_n, 32'd12);
    check({tag, "_frame_starts"}, fs_n, 32'd1);
    check({tag, "_vs_low"}, vs_low, 32'd32);
    check({tag, "_vs_first"}, vs_first, 32'd128);
    check({tag, "_hs_low"}, hs_low, 32'd36);
    check({tag, "_visible"}, von_n, 32'd48);
    check({tag, "_model_err"}, err, 32'd0);
    check({tag, "_idle_pulses"}, idle_pulse, 32'd0);
  endtask

  initial begin
    int hs_low, hs_first, vid_low, pulse_n, err;
    logic [9:0] exp_px;

    rst_a = 1'b1; pe_a = 1'b0;
    rst_b = 1'b1; pe_b = 1'b0;

    // Reset held while pix_en is high: reset wins.
    tick_a(1'b1);
    tick_a(1'b1);
    check("rst_hsync", hs_a, 32'd1);
    check("rst_vsync", vs_a, 32'd1);
    check("rst_video", von_a, 32'd0);
    check("rst_px", px_a, 32'd0);
    check("rst_py", py_a, 32'd0);
    check("rst_ls", ls_a, 32'd0);
    check("rst_fs", fs_a, 32'd0);

    // First emit after release is (0,0) with both pulses.
    rst_a = 1'b0;
    tick_a(1'b1);
    check("first_video", von_a, 32'd1);
    check("first_fs", fs_a, 32'd1);
    check("first_ls", ls_a, 32'd1);
    check("first_px", px_a, 32'd0);
    check("first_py", py_a, 32'd0);
    check("first_hsync", hs_a, 32'd1);
    tick_a(1'b0);
    check("first_ls_drop", ls_a, 32'd0);
    check("first_fs_drop", fs_a, 32'd0);
    check("first_video_held", von_a, 32'd1);

    // Rest of line 0 with pix_en every second cycle.
    hs_low = 0; hs_first = -1; vid_low = 0; pulse_n = 0; err = 0;
    for (int h = 1; h < 800; h++) begin
      tick_a(1'b1);
      exp_px = (h < 640) ? 10'(h) : 10'd0;
      if (!hs_a) begin
        hs_low++;
        if (hs_first < 0) hs_first = h;
      end
      if (!von_a) vid_low++;
      if (ls_a || fs_a) pulse_n++;
      if (px_a !== exp_px || py_a !== 10'd0 || vs_a !== 1'b1 || von_a !== (h < 640)) err++;
      tick_a(1'b0);
      if (ls_a || fs_a) pulse_n++;
    end
    check("line_hs_low", hs_low, 32'd96);
    check("line_hs_first", hs_first, 32'd656);
    check("line_video_low", vid_low, 32'd160);
    check("line_pulses", pulse_n, 32'd0);
    check("line_model_err", err, 32'd0);

    // Wrap into line 1.
    tick_a(1'b1);
    check("wrap_ls", ls_a, 32'd1);
    check("wrap_fs", fs_a, 32'd0);
    check("wrap_px", px_a, 32'd0);
    check("wrap_py", py_a, 32'd1);

    // Back-to-back pix_en: one pixel per cycle, no extra pulses.
    err = 0;
    for (int h = 1; h <= 5; h++) begin
      tick_a(1'b1);
      if (px_a !== 10'(h) || ls_a !== 1'b0 || fs_a !== 1'b0) err++;
    end
    check("b2b_err", err, 32'd0);

    // pix_en low for 50 cycles: everything held, no pulses.
    err = 0;
    for (int i = 0; i < 50; i++) begin
      tick_a(1'b0);
      if (px_a !== 10'd5 || py_a !== 10'd1 || von_a !== 1'b1 || hs_a !== 1'b1 ||
          vs_a !== 1'b1 || ls_a !== 1'b0 || fs_a !== 1'b0) err++;
    end
    check("hold_err", err, 32'd0);
    tick_a(1'b1);
    check("hold_resume_px", px_a, 32'd6);

    // Advance to hcount 700 (inside hsync) and reset together with pix_en.
    for (int h = 7; h <= 700; h++) tick_a(1'b1);
    check("h700_hsync", hs_a, 32'd0);
    check("h700_video", von_a, 32'd0);
    rst_a = 1'b1;
    tick_a(1'b1);
    check("midrst_hsync", hs_a, 32'd1);
    check("midrst_vsync", vs_a, 32'd1);
    check("midrst_video", von_a, 32'd0);
    check("midrst_py", py_a, 32'd0);
    check("midrst_ls", ls_a, 32'd0);
    rst_a = 1'b0;
    tick_a(1'b1);
    check("restart_fs", fs_a, 32'd1);
    check("restart_ls", ls_a, 32'd1);
    check("restart_px", px_a, 32'd0);
    check("restart_py", py_a, 32'd0);
    check("restart_hsync", hs_a, 32'd1);
    tick_a(1'b0);

    // Small timing: full frame at pix_en every second cycle.
    tick_b(1'b1);
    rst_b = 1'b0;
    run_frame_b(1, "half");

    // Move to (11,8): both syncs low, then reset with pix_en.
    for (int e = 1; e <= 139; e++) tick_b(1'b1);
    check("b_mid_hsync", hs_b, 32'd0);
    check("b_mid_vsync", vs_b, 32'd0);
    rst_b = 1'b1;
    tick_b(1'b1);
    check("b_rst_hsync", hs_b, 32'd1);
    check("b_rst_vsync", vs_b, 32'd1);
    check("b_rst_fs", fs_b, 32'd0);
    rst_b = 1'b0;

    // pix_en tied high: frame restarts at (0,0) and keeps the same sync positions.
    run_frame_b(0, "full");
    tick_b(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
